// File: rtl/divisao_sobel_pkg.sv
// Shared definitions for the divisao_sobel multicycle divider custom instruction.
// Holds the controller state encoding and the divide-by-zero quotient constant.
package divisao_sobel_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Quotient returned for a zero divisor, mirroring the multiplier's saturated case.
  localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divisao_sobel_step.sv
// One combinational radix-2 restoring division step.
// Kept separate so a radix-4 variant can chain two of these per cycle.
module divisao_sobel_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             non_neg;

  // The extra top bit of diff is the borrow: clear means the trial subtraction fits.
  assign shifted = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, d_i};
  assign non_neg = ~diff[WIDTH+1];

  assign r_o = non_neg ? diff[WIDTH:0] : shifted;
  assign q_o = {q_i[WIDTH-2:0], non_neg};

endmodule

// File: rtl/divisao_sobel.sv
// Nios II multicycle custom instruction: unsigned divide returning quotient (n=0)
// or remainder (n=1), with single-cycle fast paths for small divisors.
module divisao_sobel
  import divisao_sobel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic             n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

  logic             fast;
  logic [WIDTH-1:0] fast_quo, fast_rem;

  divisao_sobel_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  // Fast-path classification works on the live operands during the start cycle.
  always_comb begin
    fast     = 1'b1;
    fast_quo = '0;
    fast_rem = dataa;
    if (datab == '0) begin
      fast_quo = '1;
    end else if (datab == WIDTH'(1)) begin
      fast_quo = dataa;
      fast_rem = '0;
    end else if (datab == WIDTH'(2)) begin
      fast_quo = dataa >> 1;
      fast_rem = {{(WIDTH-1){1'b0}}, dataa[0]};
    end else if (dataa < datab) begin
      fast_quo = '0;
    end else begin
      fast = 1'b0;
    end
  end

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    if (clk_en) begin
      done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            d_d   = datab;
            n_d   = n;
            q_d   = dataa;
            r_d   = '0;
            cnt_d = '0;
            if (fast) begin
              result_d = n ? fast_rem : fast_quo;
              done_d   = 1'b1;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = n_q ? step_r[WIDTH-1:0] : step_q;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  // NOTE: all registers here are plain flops (no memory arrays), so each takes the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      n_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_divisao_sobel.sv
// Scoreboard bench for divisao_sobel: expected result and done cycle are queued at
// start time from a plain-arithmetic model; a monitor pops and compares on done.
module tb_divisao_sobel;
  import divisao_sobel_pkg::*;

  localparam int W = 32;
  localparam int GEN_LAT = W + 1;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clk_en = 1'b1;
  logic         start = 1'b0;
  logic         n = 1'b0;
  logic [W-1:0] dataa = '0;
  logic [W-1:0] datab = '0;
  logic [W-1:0] result;
  logic         done;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   seen0 = 0;

  divisao_sobel #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .n       (n),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic nn);
    if (b == 0) return nn ? a : DIV0_QUOTIENT;
    return nn ? (a % b) : (a / b);
  endfunction

  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b <= 2 || a < b) ? 1 : GEN_LAT;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: consumes one scoreboard entry per done pulse.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_cycle"}, W'(cyc), W'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic nn,
                       input int extra, input string name);
    exp_t e;
    @(posedge clk); #1;
    dataa = a; datab = b; n = nn; start = 1'b1;
    e.res = model(a, b, nn);
    e.cyc = cyc + latency(a, b) + extra;
    e.name = name;
    sb.push_back(e);
    seen0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    dataa = $urandom; datab = $urandom; n = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (done_cnt == seen0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    @(negedge clk);
    if (done_cnt == seen0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
      sb.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic nn, input string name);
    issue(a, b, nn, 0, name);
    wait_done(name);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // Traffic while reset is held must leave no trace.
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'b1; dataa = 32'd1000; datab = 32'd7;
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_done", W'(done), '0);
    check("reset_result", result, '0);

    run(32'd1000, 32'd7, 1'b0, "gen_quo");
    run(32'd1000, 32'd7, 1'b1, "gen_rem");
    run(32'h1234, 32'd0, 1'b0, "div0_quo");
    run(32'h1234, 32'd0, 1'b1, "div0_rem");
    run(32'hDEADBEEF, 32'd1, 1'b0, "div1_quo");
    run(32'hDEADBEEF, 32'd1, 1'b1, "div1_rem");
    run(32'hFFFFFFFF, 32'd2, 1'b0, "div2_quo");
    run(32'hFFFFFFFF, 32'd2, 1'b1, "div2_rem");
    run(32'd5, 32'd9, 1'b0, "small_quo");
    run(32'd5, 32'd9, 1'b1, "small_rem");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "max_quo");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "max_rem");
    run(32'hFFFFFFFF, 32'd3, 1'b0, "div3_quo");

    // clk_en stall of 10 cycles mid-BUSY, plus a spurious start while busy.
    issue(32'd1000, 32'd7, 1'b0, 10, "stall");
    repeat (5) @(posedge clk);
    #1 start = 1'b1; dataa = 32'd9; datab = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 clk_en = 1'b0;
    repeat (10) @(posedge clk);
    #1 clk_en = 1'b1;
    wait_done("stall");

    // Abort mid-division: no done may follow, then a fresh request completes.
    issue(32'd1000, 32'd7, 1'b0, 0, "abort");
    repeat (14) @(posedge clk);
    #1 reset_n = 1'b0;
    sb.delete();
    seen0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", W'(done_cnt), W'(seen0));
    run(32'd1000, 32'd7, 1'b1, "post_abort");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 0) ra = ra >> $urandom_range(0, 31);
      run(ra, rb, 1'($urandom), "rand");
    end

    repeat (3) @(posedge clk);
    check("queue_empty", W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divisao_sobel.md
Name: divisao_sobel

Overview:
- Multicycle Nios II custom instruction: unsigned 32-bit integer divider, the inverse operation of the Sobel multiplication instruction.
- Used by the Sobel stage for normalisation and averaging.
- Radix-2 restoring division; small-divisor fast paths mirror the multiplier's special cases.
- Returns the quotient or the remainder, selected by the extension bit n; Nios multicycle start/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  clock enable; when low, all state is frozen.
- start  in  1  one-cycle request; operands and n are sampled when start is high.
- n  in  1  0 selects the quotient, 1 selects the remainder.
- dataa  in  WIDTH  dividend.
- datab  in  WIDTH  divisor.
- result  out  WIDTH  quotient or remainder.
- done  out  1  one-cycle pulse; result is valid while done is high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: done=0, result=0, state=IDLE, counter=0, internal operand registers=0.
- Reset asserted mid-operation aborts immediately; no done is produced for the aborted request.
- clk_en=0: no register changes and start is not sampled. A done already high stays high until the next enabled edge.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, clk_en=1:
  - latch dataa, datab and n;
  - classify the request; take the fast path if it applies, otherwise enter BUSY.
- Fast path (next state DONE, done high in the cycle after the start cycle, latency 1):
  - datab==0: quotient=all-ones (0xFFFFFFFF), remainder=dataa.
  - datab==1: quotient=dataa, remainder=0.
  - datab==2: quotient=dataa>>1, remainder=dataa[0].
  - dataa<datab (datab>2): quotient=0, remainder=dataa.
- BUSY:
  - Registers: partial remainder R (WIDTH+1 bits), quotient/dividend shift register Q (WIDTH bits), counter (clog2(WIDTH)+1 bits).
  - Each enabled edge performs one restoring step:
    - T={R[WIDTH-1:0],Q[WIDTH-1]} - {1'b0,D};
    - if T is non-negative: R=T, shift a 1 into Q;
    - otherwise: R={R[WIDTH-1:0],Q[WIDTH-1]}, shift a 0 into Q.
  - The counter increments per step. After step WIDTH, go to DONE.
- Result register is loaded on the same edge that sets done.
- General-path latency: start sampled in cycle 0; done high in cycle WIDTH+1 (33 at default).
- DONE:
  - done=1 for exactly one enabled cycle, then IDLE with done=0.
  - result holds its value until the next request completes.
- start while BUSY or DONE is ignored; there is no queuing.
- start coincident with the DONE cycle is also ignored. The master must wait for done before issuing the next start.
- Arithmetic is unsigned only; no overflow is possible.
- Invariant: remainder < divisor for every divisor != 0.
- Operand inputs may change freely after the start cycle without affecting the operation.

Decomposition:
- Shared package divisao_sobel_pkg:
  - state enum (IDLE, BUSY, DONE);
  - WIDTH default;
  - DIV0_QUOTIENT constant (all ones).
- One sub-module, divisao_sobel_step: combinational single restoring step.
  - Inputs: R, Q, D.
  - Outputs: next R, next Q.
  - Keeps the datapath separable for reuse by a future radix-4 variant.

Test Plan:
- Reset: hold reset_n=0 during active traffic, then release -> done=0, result=0; the first request after release completes normally.
- General path: dataa=1000, datab=7, n=0 -> done high exactly 33 cycles after the start cycle, result=142. Repeat with n=1 -> result=6.
- Fast paths, each with done in the cycle after start:
  - datab=0, dataa=0x1234, n=0 -> 0xFFFFFFFF; n=1 -> 0x1234.
  - datab=1 -> dataa.
  - datab=2, dataa=0xFFFFFFFF -> quotient 0x7FFFFFFF, remainder 1.
  - dataa=5, datab=9 -> quotient 0, remainder 5.
- Extremes: dataa=0xFFFFFFFF, datab=0xFFFFFFFF -> quotient 1, remainder 0 (general path, 33 cycles). dataa=0xFFFFFFFF, datab=3 -> 0x55555555.
- clk_en stall: deassert clk_en for 10 cycles mid-BUSY with dataa=1000, datab=7 -> done arrives 43 cycles after start, result=142. Spurious start pulses during BUSY are ignored.
- Abort and random check: pulse reset_n low at cycle 15 of a division -> no done is produced; a fresh request afterwards completes correctly. Follow with 1000 random operand pairs checked against a reference model (quotient and remainder).
